// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared sizing, state encoding and helpers for the dot-product engine
package dotp_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Wide enough that a full-depth sum of maximum products cannot overflow.
  function automatic int acc_width(input int data_width, input int addr_width);
    return 2 * data_width + addr_width + 1;
  endfunction

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = clog2(DEPTH_DEF);
  localparam int ACC_WIDTH_DEF  = acc_width(DATA_WIDTH_DEF, ADDR_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dotp_mac_unit.sv
// rtl/dotp_mac_unit.sv - registered unsigned multiply-accumulate
module dotp_mac_unit
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [ACC_WIDTH-1:0] prod;
  assign prod = ACC_WIDTH'(a) * ACC_WIDTH'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - sequences lockstep reads of two vector memories and
// accumulates their dot product, presented on a valid/ready result handshake
module dot_product_engine
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  rd_en_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [DATA_WIDTH-1:0] dout_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   nc;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic                  data_valid;
  logic                  clr;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  prod;

  assign len_clamped = (len > DEPTH_N) ? DEPTH_N : len;
  assign clr         = (state == IDLE) && start;
  assign prod        = ACC_WIDTH'(dout_a) * ACC_WIDTH'(dout_b);

  // Both ports share one enable/address register so they can never diverge.
  assign rd_en_a   = rd_en;
  assign rd_en_b   = rd_en;
  assign rd_addr_a = addr;
  assign rd_addr_b = addr;

  dotp_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (data_valid),
    .a  (dout_a),
    .b  (dout_b),
    .acc(acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      addr         <= '0;
      nc           <= '0;
      data_valid   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      data_valid <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            nc   <= len_clamped;
            busy <= 1'b1;
            if (len_clamped == '0) begin
              result <= '0;
              state  <= DONE;
            end else begin
              rd_en <= 1'b1;
              addr  <= '0;
              state <= READ;
            end
          end
        end
        READ: begin
          if ({1'b0, addr} == nc - 1'b1) begin
            rd_en <= 1'b0;
            addr  <= '0;
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last element's data is on dout now; fold it in alongside the MAC.
          result       <= acc + prod;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          // A zero-length run enters here with valid low and raises it one edge later.
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - self-checking bench for dot_product_engine
module tb_dot_product_engine;

  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int ACCW = 22;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     len;
  logic            busy;
  logic            rd_en_a, rd_en_b;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [DW-1:0]   dout_a, dout_b;
  logic [ACCW-1:0] result;
  logic            result_valid;
  logic            result_ready;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  int exp_addr = 0;
  int rd_cnt = 0;

  typedef struct {
    int     n;
    int     pat;
    int     hold;
    bit     pulse;
    longint exp_res;
    int     exp_lat;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  dot_product_engine dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .dout_a(dout_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .dout_b(dout_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  // One-cycle synchronous-read memories standing in for mem_controller.
  always @(posedge clk) begin
    if (rd_en_a) dout_a <= mem_a[rd_addr_a];
    if (rd_en_b) dout_b <= mem_b[rd_addr_b];
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every issued read must be the next sequential address, identical on both ports.
  always @(negedge clk) begin
    if (!rst && rd_en_a) begin
      check("rd_addr_seq", rd_addr_a, exp_addr);
      check("port_lockstep", {rd_en_b, rd_addr_b}, {1'b1, rd_addr_a});
      exp_addr++;
      rd_cnt++;
    end
  end

  function automatic longint ref_dot(input int n);
    longint s = 0;
    int m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    return s;
  endfunction

  function automatic int ref_lat(input int n);
    return ((n > DEPTH) ? DEPTH : n) + 1;
  endfunction

  task automatic set_pattern(input int pat);
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
    case (pat)
      0: begin
        mem_a[0] = 10;  mem_a[1] = 20;  mem_a[2] = 30;
        mem_b[0] = 200; mem_b[1] = 150; mem_b[2] = 100;
      end
      1: for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 255; mem_b[i] = 255; end
      2: for (int i = 0; i < 4; i++) begin mem_a[i] = DW'(i + 1); mem_b[i] = DW'(4 - i); end
      3: begin mem_a[0] = 1; mem_a[1] = 2; mem_b[0] = 3; mem_b[1] = 4; end
      default: ;
    endcase
  endtask

  // Caller is #1 after an edge with the engine idle.
  task automatic run(input string name, input int n, input int hold, input bit pulse,
                     input longint exp_res, input int exp_lat);
    int lat;
    int exp_reads;
    exp_addr = 0;
    rd_cnt = 0;
    exp_reads = (n > DEPTH) ? DEPTH : n;
    result_ready = (hold == 0);
    start = 1'b1;
    len = (AW + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len = (AW + 1)'($urandom);
    check({name, "_busy"}, busy, 1);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_reads"}, rd_cnt, exp_reads);
    for (int i = 0; i < hold; i++) begin
      start = pulse;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, result_valid, 1);
      check({name, "_hold_result"}, result, exp_res);
      check({name, "_hold_busy"}, busy, 1);
      check({name, "_hold_rd_en"}, {rd_en_a, rd_addr_a}, 0);
    end
    start = pulse;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_accept_valid"}, result_valid, 0);
    check({name, "_accept_busy"}, busy, 0);
    check({name, "_kept_result"}, result, exp_res);
  endtask

  initial begin
    tbl[0] = '{n: 3,  pat: 0, hold: 0,  pulse: 1'b0, exp_res: 8000,    exp_lat: 4};
    tbl[1] = '{n: 32, pat: 1, hold: 0,  pulse: 1'b0, exp_res: 2080800, exp_lat: 33};
    tbl[2] = '{n: 40, pat: 1, hold: 0,  pulse: 1'b0, exp_res: 2080800, exp_lat: 33};
    tbl[3] = '{n: 0,  pat: 0, hold: 0,  pulse: 1'b0, exp_res: 0,       exp_lat: 1};
    tbl[4] = '{n: 3,  pat: 0, hold: 10, pulse: 1'b1, exp_res: 8000,    exp_lat: 4};
    tbl[5] = '{n: 4,  pat: 2, hold: 2,  pulse: 1'b0, exp_res: 20,      exp_lat: 5};

    rst = 1'b1;
    start = 1'b0;
    len = '0;
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, rd_en_a, rd_en_b, result_valid}, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      set_pattern(tbl[i].pat);
      run($sformatf("tbl%0d", i), tbl[i].n, tbl[i].hold, tbl[i].pulse,
          tbl[i].exp_res, tbl[i].exp_lat);
    end

    // Reset while address 2 of a 4-element run is being issued.
    set_pattern(2);
    exp_addr = 0;
    start = 1'b1;
    len = 4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_at_addr", rd_addr_a, 2);
    #2 rst = 1'b1;
    #1;
    check("abort_immediate", {rd_en_a, rd_en_b, busy, result_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_result", result_valid, 0);
    run("after_abort", 4, 0, 1'b0, 20, 5);

    // Back-to-back runs with memory updated between them.
    set_pattern(3);
    run("b2b_first", 2, 0, 1'b0, 11, 3);
    mem_a[0] = 5;
    mem_b[0] = 6;
    run("b2b_second", 1, 0, 1'b0, 30, 2);

    for (int i = 0; i < 24; i++) begin
      int n;
      set_pattern(99);
      n = $urandom_range(0, 40);
      run($sformatf("rand%0d_n%0d", i, n), n, $urandom_range(0, 3), 1'(i % 2),
          ref_dot(n), ref_lat(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
